// File: rtl/mdu_defs.sv
// ============================================================================
// Module   : mdu_defs (package)
// Brief    : Op encodings, latency defaults and FSM state type for the MDU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mdu_defs;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_div_core.sv
// ============================================================================
// Module   : mdu_div_core
// Brief    : Combinational 32-bit divider with signed fix-ups and /0 flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_div_core (
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_is_signed,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_div_zero
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  assign w_neg_a    = i_is_signed & i_dividend[31];
  assign w_neg_b    = i_is_signed & i_divisor[31];
  assign w_abs_a    = w_neg_a ? (~i_dividend + 32'd1) : i_dividend;
  assign w_abs_b    = w_neg_b ? (~i_divisor + 32'd1) : i_divisor;
  assign o_div_zero = (i_divisor == 32'd0);

  // Substitute 1 for a zero divisor; the caller discards the result anyway.
  assign w_den = o_div_zero ? 32'd1 : w_abs_b;
  assign w_uq  = w_abs_a / w_den;
  assign w_ur  = w_abs_a % w_den;

  assign o_quotient  = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign o_remainder = w_neg_a ? (~w_ur + 32'd1) : w_ur;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multi-cycle multiply/divide unit owning HI/LO. Optional
//            multiply-accumulate ops enabled by macro MULT_DIV_MADD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  mdu_state_t  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_op;
  logic [31:0] r_opa, r_opb;
  logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic        w_capture;
  logic        w_is_mul_op;
  logic        w_is_div_op;
  logic        w_mul_signed;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [31:0] w_quot, w_rem;
  logic        w_div_zero;

  always_comb begin
    w_is_mul_op  = (op == OP_MULT) || (op == OP_MULTU);
    w_mul_signed = (r_op == OP_MULT);
`ifdef MULT_DIV_MADD_EN
    w_is_mul_op  = w_is_mul_op || (op == OP_MADD) || (op == OP_MADDU) ||
                   (op == OP_MSUB) || (op == OP_MSUBU);
    w_mul_signed = w_mul_signed || (r_op == OP_MADD) || (r_op == OP_MSUB);
`endif
    w_is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Extending both operands to 64 bits makes the low 64 product bits correct
  // for signed and unsigned alike.
  assign w_ma   = {{32{w_mul_signed & r_opa[31]}}, r_opa};
  assign w_mb   = {{32{w_mul_signed & r_opb[31]}}, r_opb};
  assign w_prod = w_ma * w_mb;

  mdu_div_core u_div_core (
    .i_dividend  (r_opa),
    .i_divisor   (r_opb),
    .i_is_signed (r_op == OP_DIV),
    .o_quotient  (w_quot),
    .o_remainder (w_rem),
    .o_div_zero  (w_div_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_is_mul_op) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = c_mult_cnt;
            w_state_nxt = ST_RUN;
          end else if (w_is_div_op) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = c_div_cnt;
            w_state_nxt = ST_RUN;
          end else if (op == OP_MTHI) begin
            w_hi_nxt = opa;
          end else if (op == OP_MTLO) begin
            w_lo_nxt = opa;
          end
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_IDLE;
          case (r_op)
            OP_MULT, OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod;
            OP_DIV, OP_DIVU: begin
              if (!w_div_zero) begin
                w_hi_nxt = w_rem;
                w_lo_nxt = w_quot;
              end
            end
`ifdef MULT_DIV_MADD_EN
            OP_MADD, OP_MADDU: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod;
            OP_MSUB, OP_MSUBU: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - w_prod;
`endif
            default: ;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= OP_NONE;
      r_opa   <= 32'd0;
      r_opb   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_capture) begin
        r_op  <= op;
        r_opa <= opa;
        r_opb <= opb;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire
